// File: rtl/err_ctrl_pkg.sv
// Shared definitions for the error controller: FSM state encoding,
// error-source bit positions and the "no source captured" marker.
package err_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Bit positions of the individual error sources inside err_vec_i.
  // Higher indices are later pipeline stages and therefore the older
  // instruction, which is why the highest set bit wins the capture.
  localparam int SRC_INST_CACHE = 0;
  localparam int SRC_DATA_CACHE = 1;
  localparam int SRC_IF         = 2;
  localparam int SRC_IFT        = 3;
  localparam int SRC_ID         = 4;
  localparam int SRC_LAUNCH     = 5;
  localparam int SRC_EX         = 6;
  localparam int SRC_MM         = 7;
  localparam int SRC_MEM        = 8;
  localparam int SRC_WB         = 9;

  localparam int NUM_SRC_DEF = SRC_WB + 1;

  localparam logic [3:0] ERR_SRC_NONE = 4'hF;

endpackage

// File: rtl/err_ctrl_if.sv
// Bundle of the error controller's pipeline-facing signals. The master
// side drives the error strobes and handshakes, the slave side (the
// controller) drives the flush/halt commands and status.
interface err_ctrl_if #(
  parameter int NUM_SRC = 10,
  parameter int CNT_W   = 8
);

  logic [NUM_SRC-1:0] err_vec_i;
  logic               flush_done_i;
  logic               clr_req_i;

  logic               flush_o;
  logic               cpu_halt_o;
  logic               cpu_inner_error_o;
  logic [3:0]         err_src_o;
  logic [NUM_SRC-1:0] err_pending_o;
  logic [CNT_W-1:0]   err_cnt_o;
  logic               timeout_o;
  logic               clr_ack_o;
  logic [1:0]         state_o;

  modport master (
    output err_vec_i, flush_done_i, clr_req_i,
    input  flush_o, cpu_halt_o, cpu_inner_error_o, err_src_o,
           err_pending_o, err_cnt_o, timeout_o, clr_ack_o, state_o
  );

  modport slave (
    input  err_vec_i, flush_done_i, clr_req_i,
    output flush_o, cpu_halt_o, cpu_inner_error_o, err_src_o,
           err_pending_o, err_cnt_o, timeout_o, clr_ack_o, state_o
  );

endinterface

// File: rtl/err_prio_enc.sv
// Highest-index priority encoder: returns the index of the most
// significant set bit (the oldest pipeline stage) plus a valid flag.
// Indices must fit in 4 bits, so NUM_SRC is limited to 15 sources
// (4'hF is reserved for "none").
module err_prio_enc
  import err_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic [3:0]         idx_o,
  output logic               valid_o
);

  // Scan upward so that later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx_o   = ERR_SRC_NONE;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/err_ctrl.sv
// Pipeline error controller. The first error seen while idle triggers a
// pipeline flush, then a halt that persists until the host clears it.
// Every error strobe is accumulated into a sticky pending mask and a
// saturating event counter; a bounded flush wait raises a timeout flag.
module err_ctrl
  import err_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  err_ctrl_if.slave  bus
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         src_q, src_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               ack_q, ack_d;

  logic [3:0]         enc_idx;
  logic               enc_valid;

  err_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .vec_i   (bus.err_vec_i),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // Next-state and next-output computation for the flush/halt sequence.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    src_d     = src_q;
    pend_d    = pend_q | bus.err_vec_i;
    timeout_d = timeout_q;
    ack_d     = 1'b0;
    cnt_d     = (enc_valid && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_FLUSH;
          src_d   = enc_idx;
          tmo_d   = '0;
        end
      end

      ST_FLUSH: begin
        if (bus.flush_done_i) begin
          state_d   = ST_HALT;
          timeout_d = 1'b0;
        end else if (tmo_q == TMO_MAX) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_HALT: begin
        if (bus.clr_req_i) begin
          ack_d     = 1'b1;
          timeout_d = 1'b0;
          if (enc_valid) begin
            // A fresh error in the clearing cycle starts a new episode
            // seeded only by that error.
            state_d = ST_FLUSH;
            src_d   = enc_idx;
            pend_d  = bus.err_vec_i;
            tmo_d   = '0;
          end else begin
            state_d = ST_IDLE;
            src_d   = ERR_SRC_NONE;
            pend_d  = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register all controller state; reset aborts any flush or halt at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      src_q     <= ERR_SRC_NONE;
      pend_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      src_q     <= src_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.flush_o           = (state_q == ST_FLUSH);
  assign bus.cpu_halt_o        = (state_q == ST_HALT);
  assign bus.cpu_inner_error_o = (state_q != ST_IDLE);
  assign bus.err_src_o         = src_q;
  assign bus.err_pending_o     = pend_q;
  assign bus.err_cnt_o         = cnt_q;
  assign bus.timeout_o         = timeout_q;
  assign bus.clr_ack_o         = ack_q;
  assign bus.state_o           = state_q;

endmodule

// File: tb/tb_err_ctrl.sv
// Self-checking bench for err_ctrl. A behavioural model predicts the
// outputs after every clock; a monitor compares them against the DUT.
module tb_err_ctrl;

  logic clk;
  logic rst_n;

  err_ctrl_if bus ();

  err_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       flush;
    logic       halt;
    logic       inner;
    logic [3:0] src;
    logic [9:0] pend;
    logic [7:0] cnt;
    logic       tmo;
    logic       ack;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers tracking the error episode.
  int         m_state;
  int         m_src;
  logic [9:0] m_pend;
  int         m_cnt;
  logic       m_tmo;
  logic       m_ack;
  int         m_flush_cycles;

  function automatic int highestBit(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 15;
  endfunction

  function automatic void modelReset();
    m_state        = 0;
    m_src          = 15;
    m_pend         = '0;
    m_cnt          = 0;
    m_tmo          = 1'b0;
    m_ack          = 1'b0;
    m_flush_cycles = 0;
  endfunction

  function automatic void modelStep(input logic [9:0] e, input logic d, input logic c);
    if (e != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
    m_ack = 1'b0;
    if (m_state == 0) begin
      if (e != 0) begin
        m_state        = 1;
        m_src          = highestBit(e);
        m_pend         = e;
        m_flush_cycles = 0;
      end
    end else if (m_state == 1) begin
      m_pend = m_pend | e;
      if (d) begin
        m_state = 2;
        m_tmo   = 1'b0;
      end else if (m_flush_cycles == 255) begin
        m_state = 2;
        m_tmo   = 1'b1;
      end else begin
        m_flush_cycles = m_flush_cycles + 1;
      end
    end else begin
      if (c) begin
        m_ack = 1'b1;
        m_tmo = 1'b0;
        if (e != 0) begin
          m_state        = 1;
          m_src          = highestBit(e);
          m_pend         = e;
          m_flush_cycles = 0;
        end else begin
          m_state = 0;
          m_src   = 15;
          m_pend  = '0;
        end
      end else begin
        m_pend = m_pend | e;
      end
    end
  endfunction

  function automatic exp_t modelOutputs();
    exp_t x;
    x.st    = 2'(m_state);
    x.flush = (m_state == 1);
    x.halt  = (m_state == 2);
    x.inner = (m_state != 0);
    x.src   = 4'(m_src);
    x.pend  = m_pend;
    x.cnt   = 8'(m_cnt);
    x.tmo   = m_tmo;
    x.ack   = m_ack;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compareAll(input exp_t x);
    checkOutput("state",        32'(bus.state_o),           32'(x.st));
    checkOutput("flush",        32'(bus.flush_o),           32'(x.flush));
    checkOutput("halt",         32'(bus.cpu_halt_o),        32'(x.halt));
    checkOutput("inner_error",  32'(bus.cpu_inner_error_o), 32'(x.inner));
    checkOutput("err_src",      32'(bus.err_src_o),         32'(x.src));
    checkOutput("err_pending",  32'(bus.err_pending_o),     32'(x.pend));
    checkOutput("err_cnt",      32'(bus.err_cnt_o),         32'(x.cnt));
    checkOutput("timeout",      32'(bus.timeout_o),         32'(x.tmo));
    checkOutput("clr_ack",      32'(bus.clr_ack_o),         32'(x.ack));
  endtask

  task automatic checkReset();
    exp_t x;
    x.st = 2'd0; x.flush = 1'b0; x.halt = 1'b0; x.inner = 1'b0;
    x.src = 4'hF; x.pend = '0; x.cnt = '0; x.tmo = 1'b0; x.ack = 1'b0;
    compareAll(x);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input logic [9:0] e, input logic d, input logic c);
    @(negedge clk);
    bus.err_vec_i    = e;
    bus.flush_done_i = d;
    bus.clr_req_i    = c;
    modelStep(e, d, c);
    sb_q.push_back(modelOutputs());
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      x = sb_q.pop_front();
      compareAll(x);
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.err_vec_i    = '0;
    bus.flush_done_i = 1'b0;
    bus.clr_req_i    = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed: capture, flush done, clear");
    applyStimulus(10'h041, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b1, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h004, 1'b1, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b1);
    applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b1, 1'b1);

    $display("[TB] directed: flush timeout and late flush_done");
    applyStimulus(10'h001, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b1);
    applyStimulus(10'h010, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) applyStimulus(10'h000, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b1, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b0);

    $display("[TB] directed: error in the clearing cycle");
    applyStimulus(10'h200, 1'b0, 1'b1);
    applyStimulus(10'h000, 1'b1, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic [9:0] e;
      e = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'h000;
      applyStimulus(e, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(10'($urandom_range(1, 1023)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
    end

    $display("[TB] asynchronous reset while halted");
    applyStimulus(10'h000, 1'b0, 1'b1);
    applyStimulus(10'h080, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    checkOutput("halt_before_reset", 32'(bus.cpu_halt_o), 32'd1);
    bus.err_vec_i    = '0;
    bus.flush_done_i = 1'b0;
    bus.clr_req_i    = 1'b0;
    rst_n = 1'b0;
    #1;
    checkReset();
    sb_q.delete();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(10'h300, 1'b0, 1'b0);
    applyStimulus(10'h000, 1'b1, 1'b0);
    applyStimulus(10'h000, 1'b0, 1'b1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/err_ctrl.md
ERR_CTRL -- requirements
Module: err_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 10, number of error sources; bit 0 inst_cache, 1 data_cache, 2 if, 3 ift, 4 id, 5 launch, 6 ex, 7 mm, 8 mem, 9 wb.
REQ-002 Parameter TMO_W, default 8, width of the flush-timeout counter.
REQ-003 Parameter CNT_W, default 8, width of the error-event counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 err_vec_i  input  NUM_SRC  per-source error strobes, sampled every cycle.
REQ-007 flush_done_i  input  1  pipeline reports flush complete.
REQ-008 clr_req_i  input  1  debug/host request to clear the halted error.
REQ-009 flush_o  output  1  pipeline flush command.
REQ-010 cpu_halt_o  output  1  pipeline halt command.
REQ-011 cpu_inner_error_o  output  1  sticky error flag, high whenever the state is not IDLE.
REQ-012 err_src_o  output  4  index of the captured first error; 4'hF = none.
REQ-013 err_pending_o  output  NUM_SRC  sticky OR of all sources seen since last clear.
REQ-014 err_cnt_o  output  CNT_W  count of error-event cycles, saturating.
REQ-015 timeout_o  output  1  flush did not complete within the timeout window.
REQ-016 clr_ack_o  output  1  one-cycle acknowledge of an accepted clear.
REQ-017 state_o  output  2  current state: IDLE=0, FLUSH=1, HALT=2.

Function
REQ-018 The FSM SHALL have states IDLE, FLUSH, HALT; all outputs registered.
REQ-019 In IDLE, a cycle with err_vec_i != 0 SHALL move to FLUSH next edge, load err_src_o with the highest set bit index (oldest stage wins), OR err_vec_i into err_pending_o, and set cpu_inner_error_o.
REQ-020 flush_o SHALL be 1 exactly while in FLUSH (first assertion one cycle after the error strobe).
REQ-021 In FLUSH the timeout counter SHALL increment each cycle from 0; flush_done_i=1 SHALL move to HALT with timeout_o=0.
REQ-022 If the counter reaches 2^TMO_W-1 without flush_done_i, FSM SHALL move to HALT and set timeout_o=1; flush_done_i in that same cycle wins (timeout_o=0).
REQ-023 cpu_halt_o SHALL be 1 exactly while in HALT.
REQ-024 In HALT, clr_req_i=1 SHALL pulse clr_ack_o for one cycle, clear err_pending_o, err_src_o (to 4'hF), timeout_o, cpu_inner_error_o, and return to IDLE.
REQ-025 If err_vec_i != 0 in the same cycle as an accepted clear, the FSM SHALL go directly to FLUSH, re-capturing err_src_o and err_pending_o from that err_vec_i alone; clr_ack_o still pulses.
REQ-026 Errors arriving in FLUSH or HALT SHALL OR into err_pending_o without changing err_src_o.
REQ-027 err_cnt_o SHALL increment by 1 in every cycle with err_vec_i != 0, in any state, saturate at all-ones, and be cleared only by reset.
REQ-028 clr_req_i outside HALT and flush_done_i outside FLUSH SHALL be ignored (no ack, no state change).

Reset
REQ-029 While rst_n=0: state IDLE, flush_o=0, cpu_halt_o=0, cpu_inner_error_o=0, err_src_o=4'hF, err_pending_o=0, err_cnt_o=0, timeout_o=0, clr_ack_o=0, timeout counter 0; reset asserted mid-FLUSH or mid-HALT SHALL abort immediately.

Structure
REQ-030 Shared package SHALL hold state encodings, source-index constants, and ERR_SRC_NONE=4'hF.
REQ-031 Highest-index priority encoding SHALL be a sub-module err_prio_enc (NUM_SRC-bit vector in, 4-bit index plus valid out).

Verification
REQ-032 err_vec_i=10'h041 one cycle in IDLE -> next cycle state FLUSH, flush_o=1, err_src_o=6, err_pending_o=10'h041, err_cnt_o=1.
REQ-033 In FLUSH, flush_done_i after 3 cycles -> HALT, cpu_halt_o=1, timeout_o=0; clr_req_i -> clr_ack_o one-cycle pulse, IDLE, err_src_o=4'hF, err_cnt_o retained.
REQ-034 FLUSH with flush_done_i held 0 -> HALT after 255 cycles with timeout_o=1; repeat with flush_done_i on cycle 255 -> timeout_o=0.
REQ-035 In HALT, err_vec_i=10'h200 plus clr_req_i same cycle -> clr_ack_o=1, state FLUSH, err_src_o=9, err_pending_o=10'h200.
REQ-036 err_vec_i nonzero for 300 consecutive cycles -> err_cnt_o saturates at 255; rst_n pulsed low mid-HALT -> all outputs at reset values asynchronously.
